imul_var_lat_param: RTL and testbench
=====================================

IMUL_VAR_LAT_PARAM -- requirements
Module: imul_var_lat_param

Interface
REQ-001 SHALL have parameter p_nbits, default 32, meaning operand width; legal values are powers of two from 8 to 64.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port istream_val, input, 1 bit: request valid.
REQ-005 SHALL have port istream_rdy, output, 1 bit: request ready.
REQ-006 SHALL have port istream_msg, input, 2*p_nbits+1 bits: {op_signed, a[p_nbits-1:0], b[p_nbits-1:0]}.
REQ-007 SHALL have port ostream_val, output, 1 bit: response valid.
REQ-008 SHALL have port ostream_rdy, input, 1 bit: response ready.
REQ-009 SHALL have port ostream_msg, output, 2*p_nbits bits: full-width product.

Function
REQ-010 SHALL implement FSM states IDLE, CALC, DONE.
REQ-011 SHALL drive istream_rdy=1 only in IDLE with reset deasserted, and ostream_val=1 only in DONE.
REQ-012 SHALL accept a request on an edge with istream_val && istream_rdy in IDLE, then:
- latch |a| zero-extended to 2*p_nbits, |b|, and result sign;
- clear the accumulator;
- move to CALC.
REQ-013 SHALL, in each CALC cycle with b!=0:
- add (a << ctz(b)) to the accumulator;
- clear the lowest set bit of b;
- shift is relative to the unshifted latched a, with no cumulative shifting.
REQ-014 SHALL leave CALC for DONE in the cycle where the updated b equals 0, or immediately after one CALC cycle if the latched b is 0.
REQ-015 SHALL spend max(popcount(|b|),1) cycles in CALC, so ostream_val rises max(popcount(|b|),1)+1 cycles after the accepting edge.
REQ-016 SHALL compute the accumulator modulo 2^(2*p_nbits); the unsigned product never overflows.
REQ-017 SHALL, in DONE, present the accumulator on ostream_msg, two's-complement negated if the result sign is 1.
- ostream_msg SHALL remain stable while ostream_val && !ostream_rdy.
REQ-018 SHALL move DONE->IDLE on an edge with ostream_rdy=1; istream_rdy stays 0 in DONE, so no request is accepted in the same edge.
REQ-019 SHALL treat the magnitude of the most negative signed operand (1 followed by zeros) as the unsigned value 2^(p_nbits-1).
REQ-020 SHALL, when op_signed=0, treat a and b as unsigned and force the result sign to 0.
REQ-021 SHALL ignore istream_msg outside the accepting edge; ostream_msg is don't-care when ostream_val=0.

Reset
REQ-022 SHALL, on any edge with reset=1, enter IDLE from any state (including mid-CALC or DONE), discarding any in-flight operation.
REQ-023 SHALL, while reset=1, hold istream_rdy=0 and ostream_val=0; the accumulator, a and b registers need not be reset.
REQ-024 SHALL assert istream_rdy=1 in the first cycle after reset deasserts.

Configuration
REQ-025 SHALL, when IMUL_VAR_LAT_SIGNED_EN is defined, honour op_signed per REQ-012/017/019.
REQ-026 SHALL, when IMUL_VAR_LAT_SIGNED_EN is undefined:
- ignore op_signed and perform unsigned multiplication only;
- omit the magnitude and negation logic;
- keep the port list unchanged.

Structure
REQ-027 SHALL place the state enum (IDLE/CALC/DONE) and the op_signed bit index constant in shared package imul_pkg.
REQ-028 SHALL split into datapath and control, with the control FSM driving mux selects and enables only.
REQ-029 SHALL use one sub-module, imul_ctz: a parametrised lowest-set-bit priority encoder, p_nbits in, $clog2(p_nbits) out, output 0 for zero input.

Verification (p_nbits=32)
REQ-030 SHALL cover unsigned 5*7: ostream_msg=0x23, ostream_val 4 cycles after accept.
REQ-031 SHALL cover b=0 (a=0x1234): result 0, ostream_val 2 cycles after accept.
REQ-032 SHALL cover unsigned 0xFFFFFFFF*0xFFFFFFFF: result 0xFFFFFFFE00000001 after 33 cycles; with the macro, signed -3*5 gives 0xFFFFFFFFFFFFFFF1, and signed 0x80000000*0x80000000 gives 0x4000000000000000.
REQ-033 SHALL cover backpressure: ostream_rdy held 0 for 5 cycles in DONE; ostream_val stays 1, msg stable, istream_rdy stays 0; the next request is accepted only after returning to IDLE.
REQ-034 SHALL cover reset pulsed mid-CALC of 0xFFFFFFFF*0xFFFFFFFF, then 2*3 issued: no stale response appears and the result is 6.

Source files
------------

// File: rtl/imul_pkg.sv
// Shared types and constants for the variable-latency integer multiplier.
// Optional feature macro: IMUL_VAR_LAT_SIGNED_EN (signed operand support).
package imul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit position of op_signed inside istream_msg for the default 32-bit build.
  localparam int IMUL_OP_SIGNED_BIT = 64;

  // Bit position of op_signed for any operand width: it sits above {a, b}.
  function automatic int op_signed_bit(input int nbits);
    return 2 * nbits;
  endfunction

endpackage

// File: rtl/imul_ctz.sv
// Lowest-set-bit priority encoder (count trailing zeros); zero input gives 0.
module imul_ctz
  import imul_pkg::*;
#(
  parameter int p_nbits = 32
) (
  input  logic [p_nbits-1:0]         in_i,
  output logic [$clog2(p_nbits)-1:0] ctz_o
);

  localparam int CW = $clog2(p_nbits);

  // Scan from the top down so the last hit is the lowest set bit.
  always_comb begin
    ctz_o = '0;
    for (int i = p_nbits - 1; i >= 0; i--) begin
      if (in_i[i]) ctz_o = CW'(i);
    end
  end

endmodule

// File: rtl/imul_var_lat_param.sv
// Variable-latency shift-add multiplier: one cycle per set bit of |b|.
// Optional feature macro: IMUL_VAR_LAT_SIGNED_EN (honour op_signed).
module imul_var_lat_param
  import imul_pkg::*;
#(
  parameter int p_nbits = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   istream_val,
  output logic                   istream_rdy,
  input  logic [2*p_nbits:0]     istream_msg,
  output logic                   ostream_val,
  input  logic                   ostream_rdy,
  output logic [2*p_nbits-1:0]   ostream_msg
);

  localparam int CW    = $clog2(p_nbits);
  localparam int OPIDX = op_signed_bit(p_nbits);

  state_t state_q, state_d;

  logic                 loadEn;
  logic                 calcEn;
  logic [p_nbits-1:0]   aRaw, bRaw;
  logic [p_nbits-1:0]   aMag, bMag;
  logic                 signIn;
  logic [2*p_nbits-1:0] a_q, acc_q;
  logic [p_nbits-1:0]   b_q, bNext;
  logic                 bNextZero;
  logic [CW-1:0]        ctzB;

  assign aRaw = istream_msg[2*p_nbits-1:p_nbits];
  assign bRaw = istream_msg[p_nbits-1:0];

`ifdef IMUL_VAR_LAT_SIGNED_EN
  logic opSigned;
  logic sign_q;

  assign opSigned = istream_msg[OPIDX];
  // Negating the most negative value wraps to 2^(p_nbits-1), which is its true magnitude.
  assign aMag   = (opSigned && aRaw[p_nbits-1]) ? (~aRaw + p_nbits'(1)) : aRaw;
  assign bMag   = (opSigned && bRaw[p_nbits-1]) ? (~bRaw + p_nbits'(1)) : bRaw;
  assign signIn = opSigned & (aRaw[p_nbits-1] ^ bRaw[p_nbits-1]);
  assign ostream_msg = sign_q ? (~acc_q + (2*p_nbits)'(1)) : acc_q;
`else
  logic unused_op_signed;

  assign unused_op_signed = istream_msg[OPIDX];
  assign aMag        = aRaw;
  assign bMag        = bRaw;
  assign signIn      = 1'b0;
  assign ostream_msg = acc_q;
`endif

  imul_ctz #(.p_nbits(p_nbits)) u_ctz (
    .in_i  (b_q),
    .ctz_o (ctzB)
  );

  // Clearing the lowest set bit; CALC ends once nothing is left.
  assign bNext     = b_q & (b_q - p_nbits'(1));
  assign bNextZero = (bNext == '0);

  // Datapath: latch magnitudes on accept, then add one shifted copy of a per set bit of b.
  always_ff @(posedge clk) begin
    if (loadEn) begin
      a_q   <= {{p_nbits{1'b0}}, aMag};
      b_q   <= bMag;
      acc_q <= '0;
`ifdef IMUL_VAR_LAT_SIGNED_EN
      sign_q <= signIn;
`endif
    end else if (calcEn) begin
      if (b_q != '0) acc_q <= acc_q + (a_q << ctzB);
      b_q <= bNext;
    end
  end

  // Control state register; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state, handshakes and datapath enables.
  always_comb begin
    state_d     = state_q;
    loadEn      = 1'b0;
    calcEn      = 1'b0;
    istream_rdy = 1'b0;
    ostream_val = 1'b0;
    case (state_q)
      IDLE: begin
        istream_rdy = !reset;
        if (istream_val && !reset) begin
          loadEn  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        calcEn = 1'b1;
        if (bNextZero) state_d = DONE;
      end
      DONE: begin
        ostream_val = !reset;
        if (ostream_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_imul_var_lat_param.sv
// Self-checking bench for imul_var_lat_param (p_nbits = 32).
// Signed expectations follow IMUL_VAR_LAT_SIGNED_EN when it is defined.
module tb_imul_var_lat_param;

  localparam int N = 32;

  logic            clk;
  logic            reset;
  logic            istream_val;
  logic            istream_rdy;
  logic [2*N:0]    istream_msg;
  logic            ostream_val;
  logic            ostream_rdy;
  logic [2*N-1:0]  ostream_msg;

  int vectors     = 0;
  int miscompares = 0;

  logic [63:0] expQ[$];
  int          latQ[$];

  imul_var_lat_param #(.p_nbits(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .istream_val (istream_val),
    .istream_rdy (istream_rdy),
    .istream_msg (istream_msg),
    .ostream_val (ostream_val),
    .ostream_rdy (ostream_rdy),
    .ostream_msg (ostream_msg)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Last-resort guard so the run can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference product: full-width two's-complement or unsigned multiply.
  function automatic logic [63:0] modelProd(input bit s, input logic [31:0] a, input logic [31:0] b);
`ifdef IMUL_VAR_LAT_SIGNED_EN
    if (s) return 64'(longint'($signed(a)) * longint'($signed(b)));
`endif
    return {32'b0, a} * {32'b0, b};
  endfunction

  // Reference latency, counted in edges from the accepting edge (inclusive) to ostream_val.
  function automatic int modelLat(input bit s, input logic [31:0] b);
    logic [31:0] bm;
    int          cnt;
    bm = b;
`ifdef IMUL_VAR_LAT_SIGNED_EN
    if (s && b[31]) bm = -b;
`endif
    cnt = $countones(bm);
    return ((cnt == 0) ? 1 : cnt) + 1;
  endfunction

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Present a request, record its expectation and wait for the accepting edge.
  task automatic applyStimulus(input bit s, input logic [31:0] a, input logic [31:0] b, output bit ok);
    int w;
    w  = 0;
    ok = 1'b1;
    expQ.push_back(modelProd(s, a, b));
    latQ.push_back(modelLat(s, b));
    istream_msg = {s, a, b};
    istream_val = 1'b1;
    while (istream_rdy !== 1'b1) begin
      stepCycle();
      w++;
      if (w > 200) begin
        ok = 1'b0;
        break;
      end
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end
    istream_val = 1'b0;
    istream_msg = {$urandom_range(1, 0) == 1, $urandom, $urandom};
  endtask

  // Wait for a response and report its value and latency.
  task automatic checkOutput(output logic [63:0] msg, output int lat, output bit ok);
    lat = 1;
    ok  = 1'b1;
    while (ostream_val !== 1'b1) begin
      stepCycle();
      lat++;
      if (lat > 200) begin
        ok = 1'b0;
        break;
      end
    end
    msg = ostream_msg;
  endtask

  task automatic releaseResp();
    ostream_rdy = 1'b1;
    stepCycle();
    ostream_rdy = 1'b0;
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    istream_val = 1'b0;
    istream_msg = '0;
    ostream_rdy = 1'b0;
    repeat (3) stepCycle();
    vectors++;
    if (istream_rdy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rdy: got %b expected 0", istream_rdy); end
    vectors++;
    if (ostream_val !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_val: got %b expected 0", ostream_val); end
    reset = 1'b0;
    #1;
    vectors++;
    if (istream_rdy !== 1'b1) begin miscompares++; $display("[TB] FAIL post_reset_rdy: got %b expected 1", istream_rdy); end
    vectors++;
    if (ostream_val !== 1'b0) begin miscompares++; $display("[TB] FAIL post_reset_val: got %b expected 0", ostream_val); end
  endtask

  // Run a list of operations one at a time, checking value, latency and return to IDLE.
  task automatic test_table(input string name, input bit sv[], input logic [31:0] av[], input logic [31:0] bv[]);
    logic [63:0] got, exp;
    int          lat, expLat;
    bit          ok1, ok2;
    for (int i = 0; i < av.size(); i++) begin
      applyStimulus(sv[i], av[i], bv[i], ok1);
      checkOutput(got, lat, ok2);
      exp    = expQ.pop_front();
      expLat = latQ.pop_front();
      vectors++;
      if (!ok1 || !ok2) begin
        miscompares++;
        $display("[TB] FAIL %s_timeout[%0d]: got accept=%b resp=%b expected 1 1", name, i, ok1, ok2);
      end
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("[TB] FAIL %s_msg[%0d]: got %h expected %h", name, i, got, exp);
      end
      vectors++;
      if (lat !== expLat) begin
        miscompares++;
        $display("[TB] FAIL %s_lat[%0d]: got %0d expected %0d", name, i, lat, expLat);
      end
      releaseResp();
      vectors++;
      if (istream_rdy !== 1'b1 || ostream_val !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL %s_idle[%0d]: got rdy=%b val=%b expected 1 0", name, i, istream_rdy, ostream_val);
      end
    end
  endtask

  task automatic test_basic();
    test_table("basic", '{1'b0, 1'b0, 1'b0, 1'b0},
               '{32'd5, 32'h1234, 32'hFFFFFFFF, 32'd0},
               '{32'd7, 32'd0,    32'hFFFFFFFF, 32'h8000_0001});
  endtask

  task automatic test_signed();
    test_table("signed", '{1'b1, 1'b1, 1'b1, 1'b1},
               '{32'hFFFFFFFD, 32'h80000000, 32'd9,        32'hFFFFFFFF},
               '{32'd5,        32'h80000000, 32'hFFFFFFF9, 32'hFFFFFFFF});
  endtask

  task automatic test_random();
    bit          sv[];
    logic [31:0] av[], bv[];
    sv = new[6];
    av = new[6];
    bv = new[6];
    for (int i = 0; i < 6; i++) begin
      sv[i] = ($urandom_range(1, 0) == 1);
      av[i] = $urandom;
      bv[i] = $urandom;
    end
    test_table("random", sv, av, bv);
  endtask

  task automatic test_back_to_back();
    test_table("b2b", '{1'b0, 1'b0, 1'b0}, '{32'd1, 32'd3, 32'hAAAA5555}, '{32'd1, 32'd12, 32'h00F0});
  endtask

  task automatic test_backpressure();
    logic [63:0] got, exp, held;
    int          lat, expLat;
    bit          ok1, ok2;
    applyStimulus(1'b0, 32'd11, 32'd13, ok1);
    checkOutput(held, lat, ok2);
    exp    = expQ.pop_front();
    expLat = latQ.pop_front();
    vectors++;
    if (!ok1 || !ok2 || held !== exp || lat !== expLat) begin
      miscompares++;
      $display("[TB] FAIL bp_first: got %h lat %0d expected %h lat %0d", held, lat, exp, expLat);
    end
    istream_msg = {1'b0, 32'd2, 32'd3};
    istream_val = 1'b1;
    for (int i = 0; i < 5; i++) begin
      stepCycle();
      vectors++;
      if (ostream_val !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_val[%0d]: got %b expected 1", i, ostream_val); end
      vectors++;
      if (ostream_msg !== held) begin miscompares++; $display("[TB] FAIL bp_msg[%0d]: got %h expected %h", i, ostream_msg, held); end
      vectors++;
      if (istream_rdy !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_rdy[%0d]: got %b expected 0", i, istream_rdy); end
    end
    releaseResp();
    vectors++;
    if (istream_rdy !== 1'b1 || ostream_val !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL bp_idle: got rdy=%b val=%b expected 1 0", istream_rdy, ostream_val);
    end
    istream_val = 1'b0;
    applyStimulus(1'b0, 32'd2, 32'd3, ok1);
    checkOutput(got, lat, ok2);
    exp    = expQ.pop_front();
    expLat = latQ.pop_front();
    vectors++;
    if (!ok1 || !ok2 || got !== exp || lat !== expLat) begin
      miscompares++;
      $display("[TB] FAIL bp_second: got %h lat %0d expected %h lat %0d", got, lat, exp, expLat);
    end
    releaseResp();
  endtask

  task automatic test_reset_mid_calc();
    logic [63:0] got, exp;
    int          lat, expLat;
    bit          ok1, ok2;
    applyStimulus(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, ok1);
    void'(expQ.pop_back());
    void'(latQ.pop_back());
    repeat (5) stepCycle();
    reset = 1'b1;
    stepCycle();
    vectors++;
    if (istream_rdy !== 1'b0 || ostream_val !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rst_mid_hold: got rdy=%b val=%b expected 0 0", istream_rdy, ostream_val);
    end
    stepCycle();
    reset = 1'b0;
    #1;
    vectors++;
    if (istream_rdy !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_mid_rdy: got %b expected 1", istream_rdy); end
    applyStimulus(1'b0, 32'd2, 32'd3, ok2);
    checkOutput(got, lat, ok2);
    exp    = expQ.pop_front();
    expLat = latQ.pop_front();
    vectors++;
    if (!ok1 || !ok2) begin miscompares++; $display("[TB] FAIL rst_mid_timeout: got %b %b expected 1 1", ok1, ok2); end
    vectors++;
    if (got !== exp) begin miscompares++; $display("[TB] FAIL rst_mid_msg: got %h expected %h", got, exp); end
    vectors++;
    if (lat !== expLat) begin miscompares++; $display("[TB] FAIL rst_mid_lat: got %0d expected %0d", lat, expLat); end
    releaseResp();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_calc();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
